// File: rtl/rd_burst_ctrl.sv
// Burst read sequencer: issues consecutive SRAM reads under a credit limit and
// streams the returned words out through a small FIFO with a last flag.
module rd_burst_ctrl #(
    parameter int SRAM_WIDTH = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [SRAM_WIDTH-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SRAM_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;
    localparam logic [PW-1:0]        PTR_ONE = 1;
    localparam logic [CW-1:0]        CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  issue_cnt;
    logic [LEN_WIDTH-1:0]  ret_cnt;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         inflight;
    logic [CW:0]           credit;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [SRAM_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];
    logic                  cmd_fire;
    logic                  ar_fire;
    logic                  push;
    logic                  pop;
    logic                  last_tag;

    assign rready    = 1'b1;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Credit covers both buffered words and requests still in the SRAM pipe.
    assign credit  = {1'b0, fifo_count} + {1'b0, inflight};
    assign arvalid = (state == ISSUE) && (credit < (CW + 1)'(FIFO_DEPTH));
    assign araddr  = base + ADDR_WIDTH'(issue_cnt);
    assign ar_fire = arvalid && arready;

    // A return with nothing in flight is a leftover from an aborted burst.
    assign push     = rvalid && rready && (inflight != '0);
    assign last_tag = (ret_cnt == len - LEN_ONE);

    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            len       <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) ret_cnt <= ret_cnt + LEN_ONE;
            unique case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        base      <= cmd_addr;
                        len       <= cmd_len;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        if (cmd_len == '0) done  <= 1'b1;
                        else               state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ar_fire) begin
                        issue_cnt <= issue_cnt + LEN_ONE;
                        if (issue_cnt == len - LEN_ONE) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_count <= '0;
            inflight   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      fifo_count <= fifo_count + CNT_ONE;
            else if (!push && pop) fifo_count <= fifo_count - CNT_ONE;
            if (ar_fire && !push)      inflight <= inflight + CNT_ONE;
            else if (!ar_fire && push) inflight <= inflight - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= rdata;
            fifo_last[wr_ptr] <= last_tag;
        end
    end

endmodule

// File: tb/tb_rd_burst_ctrl.sv
// Bench for rd_burst_ctrl: 1-cycle SRAM wrapper model plus a queue-based
// reference of expected addresses and output words per burst.
module tb_rd_burst_ctrl;

    localparam int SW = 128;
    localparam int AW = 6;
    localparam int LW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic          rvalid = 1'b0;
    logic          rready;
    logic [SW-1:0] rdata = '0;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [SW-1:0] mem [1 << AW];

    int errors = 0;
    int checks = 0;
    int first_out;
    int done_cyc;
    int issued_at_11;
    int stall_obs;

    rd_burst_ctrl #(
        .SRAM_WIDTH(SW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM wrapper: one-cycle read latency.
    always @(posedge clk) begin
        rvalid <= arvalid && arready;
        rdata  <= mem[araddr];
    end

    function automatic logic pick_ready(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom % 2);
        return (c < 12) ? 1'b0 : 1'(c % 2);
    endfunction

    // Runs one burst; omode/amode select out_ready and arready patterns.
    task automatic run_burst(input logic [AW-1:0] a, input logic [LW-1:0] n,
                             input int omode, input int amode);
        logic [AW-1:0] qa[$];
        logic [SW-1:0] qd[$];
        logic          ql[$];
        int  issued, popped, stall_left, prev_issue;
        bit  last_hs, exp_done, exp_busy, finished, stall_done;
        for (int i = 0; i < int'(n); i++) begin
            qa.push_back(AW'(int'(a) + i));
            qd.push_back(mem[AW'(int'(a) + i)]);
            ql.push_back(i == int'(n) - 1);
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = n;
        out_ready = pick_ready(omode, 1);
        arready   = (amode == 1) ? 1'($urandom % 4 != 0) : 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1)
            begin errors++; $display("FAIL cmd_accept got=%b want=1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_len   = LW'($urandom);
        issued = 0; popped = 0; stall_left = 0; prev_issue = -1;
        last_hs = (n == 0); finished = 0; stall_done = 0;
        first_out = -1; done_cyc = -1; issued_at_11 = -1; stall_obs = 0;
        for (int cyc = 1; cyc <= 800 && !finished; cyc++) begin
            @(negedge clk);
            exp_done = last_hs;
            last_hs  = 0;
            exp_busy = (n != 0) && !exp_done;
            checks++;
            if (done !== exp_done)
                begin errors++; $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, exp_done); end
            checks++;
            if (busy !== exp_busy || cmd_ready !== !exp_busy || rready !== 1'b1)
                begin errors++; $display("FAIL busy_ready cyc=%0d busy=%b cmd_ready=%b rready=%b want busy=%b", cyc, busy, cmd_ready, rready, exp_busy); end
            if (arvalid) begin
                checks++;
                if (qa.size() == 0)
                    begin errors++; $display("FAIL extra_arvalid cyc=%0d araddr=%0d want none", cyc, araddr); end
                else if (araddr !== qa[0])
                    begin errors++; $display("FAIL araddr cyc=%0d got=%0d want=%0d", cyc, araddr, qa[0]); end
                if (!arready) stall_obs++;
                if (arready && qa.size() != 0) begin
                    void'(qa.pop_front());
                    issued++;
                    if (omode == 0 && amode == 0 && prev_issue >= 0) begin
                        checks++;
                        if (cyc != prev_issue + 1)
                            begin errors++; $display("FAIL throughput issue cyc=%0d want=%0d", cyc, prev_issue + 1); end
                    end
                    prev_issue = cyc;
                end
            end
            checks++;
            if (out_valid && qd.size() == 0)
                begin errors++; $display("FAIL spurious_out cyc=%0d data=%h want no valid", cyc, out_data); end
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid && out_ready && qd.size() != 0) begin
                checks++;
                if (out_data !== qd[0] || out_last !== ql[0])
                    begin errors++; $display("FAIL out_word cyc=%0d got=%h/%b want=%h/%b", cyc, out_data, out_last, qd[0], ql[0]); end
                last_hs = ql[0];
                void'(qd.pop_front());
                void'(ql.pop_front());
                popped++;
            end
            checks++;
            if (issued - popped > FD)
                begin errors++; $display("FAIL overflow cyc=%0d outstanding=%0d want<=%0d", cyc, issued - popped, FD); end
            if (cyc == 11) issued_at_11 = issued;
            if (exp_done) begin done_cyc = cyc; finished = 1; end
            @(posedge clk); #1;
            out_ready = pick_ready(omode, cyc + 1);
            if (amode == 2 && issued == 2 && !stall_done) begin
                stall_left = 3;
                stall_done = 1;
            end
            if (amode == 1)      arready = 1'($urandom % 4 != 0);
            else if (stall_left > 0) begin arready = 1'b0; stall_left--; end
            else                 arready = 1'b1;
        end
        checks++;
        if (!finished || qa.size() != 0 || qd.size() != 0)
            begin errors++; $display("FAIL burst_end finished=%0d addr_left=%0d words_left=%0d want 1/0/0", finished, qa.size(), qd.size()); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0)
            begin errors++; $display("FAIL done_pulse got=%b want=0", done); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        arready = 1'b1; out_ready = 1'b1;
        #12;
        checks++;
        if (cmd_ready !== 1'b1 || arvalid !== 1'b0 || araddr !== '0 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rready !== 1'b1)
            begin errors++; $display("FAIL reset_state cr=%b av=%b aa=%0d ov=%b ol=%b b=%b d=%b rr=%b", cmd_ready, arvalid, araddr, out_valid, out_last, busy, done, rready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_burst(6'd5, 8'd4, 0, 0);
    endtask

    task automatic test_latency();
        run_burst(6'd17, 8'd1, 0, 0);
        checks++;
        if (first_out != 3 || done_cyc != 4)
            begin errors++; $display("FAIL latency out=%0d done=%0d want 3/4", first_out, done_cyc); end
    endtask

    task automatic test_wrap();
        run_burst(6'd62, 8'd4, 0, 0);
    endtask

    task automatic test_backpressure();
        run_burst(6'd30, 8'd10, 2, 0);
        checks++;
        if (issued_at_11 != FD)
            begin errors++; $display("FAIL credit_stop issued=%0d want=%0d", issued_at_11, FD); end
    endtask

    task automatic test_zero_len();
        run_burst(6'd9, 8'd0, 0, 0);
    endtask

    task automatic test_ar_stall();
        run_burst(6'd40, 8'd6, 0, 2);
        checks++;
        if (stall_obs != 3)
            begin errors++; $display("FAIL ar_stall held=%0d want=3", stall_obs); end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_addr = 6'd1; cmd_len = 8'd0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1)
            begin errors++; $display("FAIL b2b_first got=%b want=1", cmd_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b1)
            begin errors++; $display("FAIL b2b_done_accept done=%b cr=%b want 1/1", done, cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL b2b_second done=%b busy=%b want 1/0", done, busy); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0)
            begin errors++; $display("FAIL b2b_quiet done=%b want=0", done); end
        @(posedge clk); #1;
        run_burst(6'd50, 8'd3, 0, 0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        cmd_valid = 1'b1; cmd_addr = 6'd20; cmd_len = 8'd8;
        out_ready = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (arvalid && arready) n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 3)
            begin errors++; $display("FAIL mid_issue issued=%0d want=3", n); end
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || arvalid !== 1'b0 || araddr !== '0 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rready !== 1'b1)
            begin errors++; $display("FAIL mid_reset cr=%b av=%b aa=%0d ov=%b b=%b d=%b", cmd_ready, arvalid, araddr, out_valid, busy, done); end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || arvalid !== 1'b0)
                begin errors++; $display("FAIL stale_flush c=%0d ov=%b busy=%b av=%b want 0", c, out_valid, busy, arvalid); end
            @(posedge clk); #1;
        end
        run_burst(6'd0, 8'd2, 0, 0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++)
            run_burst(AW'($urandom), LW'($urandom_range(1, 20)), 1, 1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_basic();
        test_latency();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_ar_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
